// File: rtl/walk_pkg.sv
// Shared types and default timing for the pedestrian-crossing controller.
package walk_pkg;

   // Controller phases, in the order they are visited.
   typedef enum logic [2:0] {
      GREEN   = 3'd0,
      YELLOW  = 3'd1,
      ALLRED1 = 3'd2,
      WALK    = 3'd3,
      FLASH   = 3'd4,
      ALLRED2 = 3'd5
   } walk_state_e;

   // Default geometry and phase durations, all counted in ticks.
   localparam int unsigned DEF_N_XING      = 2;
   localparam int unsigned DEF_CNT_W       = 8;
   localparam int unsigned DEF_T_GREEN_MIN = 20;
   localparam int unsigned DEF_T_YELLOW    = 4;
   localparam int unsigned DEF_T_ALLRED    = 2;
   localparam int unsigned DEF_T_WALK      = 10;
   localparam int unsigned DEF_T_FLASH     = 6;

   // A duration is usable when it is non-zero and its terminal count fits the counter.
   function automatic bit timing_ok(input int unsigned t, input int unsigned w);
      return (t >= 1) && (t < (32'd1 << w));
   endfunction

endpackage

// File: rtl/walk_req_latch.sv
// One crosswalk request latch: set by a button pulse, cleared when the channel is served.
module walk_req_latch (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic clr,
   output logic pending
);

   // Clear has priority so a press on the serve cycle is absorbed by the phase it starts.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         pending <= 1'b0;
      end else if (clr) begin
         pending <= 1'b0;
      end else if (set) begin
         pending <= 1'b1;
      end
   end

endmodule

// File: rtl/walk_xing_ctrl.sv
// Pedestrian-crossing controller: latches walk requests per crosswalk and runs
// the vehicle lights through green, yellow, all-red, walk, flash and all-red.
module walk_xing_ctrl
   import walk_pkg::*;
#(
   parameter int unsigned N_XING      = DEF_N_XING,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned T_GREEN_MIN = DEF_T_GREEN_MIN,
   parameter int unsigned T_YELLOW    = DEF_T_YELLOW,
   parameter int unsigned T_ALLRED    = DEF_T_ALLRED,
   parameter int unsigned T_WALK      = DEF_T_WALK,
   parameter int unsigned T_FLASH     = DEF_T_FLASH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [N_XING-1:0] req,
   output logic [N_XING-1:0] req_pending,
   output logic [N_XING-1:0] walk,
   output logic [N_XING-1:0] dont_walk,
   output logic              veh_green,
   output logic              veh_yellow,
   output logic              veh_red,
   output logic              busy
);

   // Reject configurations the counter cannot time.
   if (!(N_XING >= 1 &&
         timing_ok(T_GREEN_MIN, CNT_W) && timing_ok(T_YELLOW, CNT_W) &&
         timing_ok(T_ALLRED, CNT_W) && timing_ok(T_WALK, CNT_W) &&
         timing_ok(T_FLASH, CNT_W))) begin : g_param_err
      $error("walk_xing_ctrl: N_XING must be >=1 and every T_* must be in [1, 2**CNT_W-1]");
   end

   // Terminal counts: a timed phase ends on the tick that finds cnt at these values.
   localparam logic [CNT_W-1:0] LIM_GREEN  = CNT_W'(T_GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(T_ALLRED - 1);
   localparam logic [CNT_W-1:0] LIM_WALK   = CNT_W'(T_WALK - 1);
   localparam logic [CNT_W-1:0] LIM_FLASH  = CNT_W'(T_FLASH - 1);

   walk_state_e       state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt, lim;
   logic [N_XING-1:0] served, served_nxt;
   logic [N_XING-1:0] pending, clr;
   logic              flash_ph, flash_nxt;
   logic              serve;

   // Per-crosswalk request latches; only channels actually captured for this walk phase are cleared.
   for (genvar i = 0; i < N_XING; i++) begin : g_latch
      walk_req_latch u_latch (
         .clk     (clk),
         .rst     (rst),
         .set     (req[i]),
         .clr     (clr[i]),
         .pending (pending[i])
      );
   end

   assign clr = {N_XING{serve}} & pending;

   // State, phase timer, served set and flash phase register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= GREEN;
         cnt      <= '0;
         served   <= '0;
         flash_ph <= 1'b1;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         served   <= served_nxt;
         flash_ph <= flash_nxt;
      end
   end

   // Next-state logic: advance the phase timer on tick and leave a phase at its terminal count.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_nxt  = state;
      cnt_nxt    = cnt;
      served_nxt = served;
      flash_nxt  = flash_ph;
      serve      = 1'b0;

      unique case (state)
         GREEN:            lim = LIM_GREEN;
         YELLOW:           lim = LIM_YELLOW;
         ALLRED1, ALLRED2: lim = LIM_ALLRED;
         WALK:             lim = LIM_WALK;
         FLASH:            lim = LIM_FLASH;
         default:          lim = LIM_GREEN;
      endcase

      if (tick) begin
         if (cnt != lim) begin
            cnt_nxt = cnt + CNT_W'(1);
         end else begin
            cnt_nxt = '0;
            unique case (state)
               GREEN: begin
                  if (|pending) begin
                     state_nxt = YELLOW;
                  end else begin
                     cnt_nxt = cnt;   // green saturates until someone asks to cross
                  end
               end
               YELLOW:  state_nxt = ALLRED1;
               ALLRED1: begin
                  state_nxt  = WALK;
                  served_nxt = pending;
                  serve      = 1'b1;
               end
               WALK: begin
                  state_nxt = FLASH;
                  flash_nxt = 1'b1;
               end
               FLASH:   state_nxt = ALLRED2;
               ALLRED2: begin
                  state_nxt  = GREEN;
                  served_nxt = '0;
               end
               default: state_nxt = GREEN;
            endcase
         end
         if (state == FLASH) begin
            flash_nxt = ~flash_ph;
         end
      end
   end

   // Lamp decode straight from registered state; walk and dont_walk are mutually exclusive.
   assign veh_green   = (state == GREEN);
   assign veh_yellow  = (state == YELLOW);
   assign veh_red     = (state == ALLRED1) || (state == WALK) ||
                        (state == FLASH)   || (state == ALLRED2);
   assign busy        = (state != GREEN);
   assign walk        = (state == WALK) ? served : '0;
   assign dont_walk   = (state == FLASH) ? (~served | {N_XING{flash_ph}}) : ~walk;
   assign req_pending = pending;

endmodule

// File: tb/tb_walk_xing_ctrl.sv
// Self-checking bench for walk_xing_ctrl with default parameters (two crosswalks).
module tb_walk_xing_ctrl;

   typedef enum int {P_G, P_Y, P_R} ph_e;

   typedef struct packed {
      logic [1:0] pend;
      logic [1:0] walk;
      logic [1:0] dw;
      logic       g;
      logic       y;
      logic       r;
      logic       busy;
   } out_t;

   // One stimulus segment: inputs held for ncyc cycles (req only on the first), outputs constant throughout.
   typedef struct {
      bit         do_rst;
      logic [1:0] req;
      logic       tick;
      int         ncyc;
      out_t       exp;
   } seg_t;

   typedef struct {
      out_t exp;
      int   seg;
      int   cyc;
   } sb_t;

   localparam out_t RST_EXP = '{pend: 2'b00, walk: 2'b00, dw: 2'b11,
                                g: 1'b1, y: 1'b0, r: 1'b0, busy: 1'b0};

   logic       clk;
   logic       rst;
   logic       tick;
   logic [1:0] req;
   logic [1:0] req_pending;
   logic [1:0] walk;
   logic [1:0] dont_walk;
   logic       veh_green;
   logic       veh_yellow;
   logic       veh_red;
   logic       busy;

   int   n_run  = 0;
   int   n_fail = 0;
   seg_t segs[$];
   sb_t  sb_q[$];

   walk_xing_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .req         (req),
      .req_pending (req_pending),
      .walk        (walk),
      .dont_walk   (dont_walk),
      .veh_green   (veh_green),
      .veh_yellow  (veh_yellow),
      .veh_red     (veh_red),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t dut_out();
      return out_t'({req_pending, walk, dont_walk, veh_green, veh_yellow, veh_red, busy});
   endfunction

   function automatic seg_t mk(bit r, logic [1:0] rq, logic tk, int n, ph_e ph,
                               logic [1:0] pend, logic [1:0] wk, logic [1:0] dw);
      seg_t s;
      s.do_rst   = r;
      s.req      = rq;
      s.tick     = tk;
      s.ncyc     = n;
      s.exp.pend = pend;
      s.exp.walk = wk;
      s.exp.dw   = dw;
      s.exp.g    = (ph == P_G);
      s.exp.y    = (ph == P_Y);
      s.exp.r    = (ph == P_R);
      s.exp.busy = (ph != P_G);
      return s;
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got pend=%b walk=%b dw=%b gyr=%b%b%b busy=%b, want pend=%b walk=%b dw=%b gyr=%b%b%b busy=%b",
                  name, act.pend, act.walk, act.dw, act.g, act.y, act.r, act.busy,
                  exp.pend, exp.walk, exp.dw, exp.g, exp.y, exp.r, exp.busy);
      end
   endtask

   // Drive one segment; each cycle's expectation goes to the scoreboard at drive time.
   task automatic run_seg(input int k);
      seg_t s;
      sb_t  e;
      s = segs[k];
      for (int c = 0; c < s.ncyc; c++) begin
         @(negedge clk);
         if (c == 0 && s.do_rst) begin
            req  = 2'b00;
            tick = 1'b0;
            rst  = 1'b1;
            #1;
            check($sformatf("seg%0d_reset", k), dut_out(), RST_EXP);
            #1;
            rst = 1'b0;
         end
         req  = (c == 0) ? s.req : 2'b00;
         tick = s.tick;
         e.exp = s.exp;
         e.seg = k;
         e.cyc = c;
         sb_q.push_back(e);
      end
   endtask

   // Scoreboard consumer: compare the oldest expectation just after each rising edge.
   initial begin
      sb_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("seg%0d_cyc%0d", e.seg, e.cyc), dut_out(), e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      out_t walk_exp;
      rst  = 1'b1;
      tick = 1'b0;
      req  = 2'b00;

      // Idle: green holds forever with nobody waiting.
      segs.push_back(mk(1, 2'b00, 1, 100, P_G, 2'b00, 2'b00, 2'b11));
      // Channel 0 request at cycle 5, channel 1 request during the walk it cannot join.
      segs.push_back(mk(1, 2'b00, 1, 4,  P_G, 2'b00, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b01, 1, 15, P_G, 2'b01, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 4,  P_Y, 2'b01, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 2,  P_R, 2'b01, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 4,  P_R, 2'b00, 2'b01, 2'b10));
      segs.push_back(mk(0, 2'b10, 1, 6,  P_R, 2'b10, 2'b01, 2'b10));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b10, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b10, 2'b00, 2'b10));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b10, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b10, 2'b00, 2'b10));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b10, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b10, 2'b00, 2'b10));
      segs.push_back(mk(0, 2'b00, 1, 2,  P_R, 2'b10, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 20, P_G, 2'b10, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 4,  P_Y, 2'b10, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 2,  P_R, 2'b10, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 10, P_R, 2'b00, 2'b10, 2'b01));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b01));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b01));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b01));
      segs.push_back(mk(0, 2'b00, 1, 2,  P_R, 2'b00, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 30, P_G, 2'b00, 2'b00, 2'b11));
      // Both channels together; a channel-0 press on the serve cycle is swallowed.
      segs.push_back(mk(1, 2'b11, 1, 19, P_G, 2'b11, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 4,  P_Y, 2'b11, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 2,  P_R, 2'b11, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b01, 1, 1,  P_R, 2'b00, 2'b11, 2'b00));
      segs.push_back(mk(0, 2'b00, 1, 9,  P_R, 2'b00, 2'b11, 2'b00));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b00));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b00));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b00, 2'b00));
      segs.push_back(mk(0, 2'b00, 1, 2,  P_R, 2'b00, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 5,  P_G, 2'b00, 2'b00, 2'b11));
      // Tick held low in yellow: timer frozen, a new press still latches.
      segs.push_back(mk(1, 2'b01, 1, 19, P_G, 2'b01, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_Y, 2'b01, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b10, 0, 50, P_Y, 2'b11, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 3,  P_Y, 2'b11, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 2,  P_R, 2'b11, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 1,  P_R, 2'b00, 2'b11, 2'b00));
      // Run into the walk phase ahead of the asynchronous reset sequence.
      segs.push_back(mk(1, 2'b01, 1, 19, P_G, 2'b01, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 4,  P_Y, 2'b01, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 2,  P_R, 2'b01, 2'b00, 2'b11));
      segs.push_back(mk(0, 2'b00, 1, 3,  P_R, 2'b00, 2'b01, 2'b10));

      for (int k = 0; k < segs.size(); k++) begin
         run_seg(k);
      end
      @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_run++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end

      // Reset asserted between edges in the middle of a walk takes effect at once.
      walk_exp = mk(0, 2'b00, 1, 1, P_R, 2'b00, 2'b01, 2'b10).exp;
      @(negedge clk);
      tick = 1'b1;
      check("pre_rst_walk", dut_out(), walk_exp);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_mid_walk", dut_out(), RST_EXP);
      @(posedge clk);
      #1;
      check("rst_held_over_edge", dut_out(), RST_EXP);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("green_after_rst", dut_out(), RST_EXP);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
